// File: rtl/eda_regional_max_iter.sv
// Iterative regional-maximum engine over an MxN image: flags start at 1 and raster
// passes clear every non-maximum in place until a full pass leaves all flags untouched.
module eda_regional_max_iter #(
  parameter int M           = 6,
  parameter int N           = 6,
  parameter int PIXEL_WIDTH = 8,
  parameter int I_WIDTH     = $clog2(M),
  parameter int J_WIDTH     = $clog2(N),
  parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH,
  parameter int PASS_WIDTH  = $clog2(M*N+2)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   write_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   conn8,
  input  logic                   start,
  input  logic                   clear,
  output logic                   busy,
  output logic                   done,
  output logic [PASS_WIDTH-1:0]  pass_count,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_flag
);

  typedef enum logic [1:0] {IDLE, INIT, SCAN, FIN} state_t;

  state_t state_q, state_d;

  logic [PIXEL_WIDTH-1:0] pixels [M][N];
  logic                   flags  [M][N];

  logic [I_WIDTH-1:0] si;
  logic [J_WIDTH-1:0] sj;
  logic               changed_q;
  logic               conn8_q;

  logic [I_WIDTH-1:0] wi, ri, ni;
  logic [J_WIDTH-1:0] wj, rj, nj;
  logic               wr_ok, rd_ok;
  logic               last_pix;
  logic               clr_hit, clear_now;
  int                 ni_s, nj_s;

  assign wi = wr_addr[ADDR_WIDTH-1:J_WIDTH];
  assign wj = wr_addr[J_WIDTH-1:0];
  assign ri = rd_addr[ADDR_WIDTH-1:J_WIDTH];
  assign rj = rd_addr[J_WIDTH-1:0];

  assign wr_ok    = write_en && (state_q == IDLE) && (int'(wi) < M) && (int'(wj) < N);
  assign rd_ok    = (int'(ri) < M) && (int'(rj) < N);
  assign last_pix = (int'(si) == M-1) && (int'(sj) == N-1);

  assign busy = (state_q == INIT) || (state_q == SCAN);
  assign done = (state_q == FIN);

  // Neighbour scan around the current pixel: k walks the 3x3 window, odd k are the
  // four orthogonal neighbours, even k (except the centre) are the diagonals.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no path
    // leaves it unassigned; a missing default here would infer a latch.
    clr_hit = 1'b0;
    ni_s    = 0;
    nj_s    = 0;
    ni      = '0;
    nj      = '0;
    for (int k = 0; k < 9; k++) begin
      ni_s = int'(si) + k / 3 - 1;
      nj_s = int'(sj) + k % 3 - 1;
      ni   = ni_s[I_WIDTH-1:0];
      nj   = nj_s[J_WIDTH-1:0];
      if (k != 4 && (conn8_q || (k % 2 == 1)) &&
          ni_s >= 0 && ni_s < M && nj_s >= 0 && nj_s < N) begin
        if ((pixels[ni][nj] > pixels[si][sj]) ||
            ((pixels[ni][nj] == pixels[si][sj]) && !flags[ni][nj]))
          clr_hit = 1'b1;
      end
    end
  end

  assign clear_now = (state_q == SCAN) && flags[si][sj] && clr_hit;

  // NOTE: state and all other registers are written with non-blocking assignments so
  // every flop samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = INIT;
        INIT:    state_d = SCAN;
        SCAN:    if (last_pix && !(changed_q || clear_now)) state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Scan pointer, pass counter and per-pass change tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      si         <= '0;
      sj         <= '0;
      pass_count <= '0;
      changed_q  <= 1'b0;
      conn8_q    <= 1'b0;
    end else if (!clear) begin
      case (state_q)
        IDLE: if (start) conn8_q <= conn8;
        INIT: begin
          si         <= '0;
          sj         <= '0;
          pass_count <= '0;
          changed_q  <= 1'b0;
        end
        SCAN: begin
          if (last_pix) begin
            si         <= '0;
            sj         <= '0;
            pass_count <= pass_count + 1'b1;
            changed_q  <= 1'b0;
          end else begin
            changed_q <= changed_q | clear_now;
            if (int'(sj) == N-1) begin
              sj <= '0;
              si <= si + 1'b1;
            end else begin
              sj <= sj + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the image lives in flops, not a RAM macro, because an asynchronous reset must
  // zero every pixel; memories without that requirement should stay unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          pixels[i][j] <= '0;
    end else if (wr_ok) begin
      pixels[wi][wj] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || clear) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          flags[i][j] <= 1'b0;
    end else if (state_q == INIT) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          flags[i][j] <= 1'b1;
    end else if (clear_now) begin
      flags[si][sj] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_flag <= 1'b0;
    else          rd_flag <= rd_ok ? flags[ri][rj] : 1'b0;
  end

endmodule

// File: tb/tb_eda_regional_max_iter.sv
// Randomised bench for eda_regional_max_iter: flags are predicted with a plateau flood
// fill, pass counts and latency with an array-level model of the pass rules.
module tb_eda_regional_max_iter;

  localparam int M      = 6;
  localparam int N      = 6;
  localparam int MN     = M * N;
  localparam int BUDGET = 4000;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       write_en = 1'b0, conn8 = 1'b0, start = 1'b0, clear = 1'b0;
  logic [5:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] pixel_in = '0;
  logic       busy, done, rd_flag;
  logic [5:0] pass_count;

  int total = 0;
  int bad   = 0;
  int img [M][N];

  always #5 clk = ~clk;

  eda_regional_max_iter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .write_en  (write_en),
    .wr_addr   (wr_addr),
    .pixel_in  (pixel_in),
    .conn8     (conn8),
    .start     (start),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .pass_count(pass_count),
    .rd_addr   (rd_addr),
    .rd_flag   (rd_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit nb_ok(int di, int dj, bit c8, int i, int j);
    if (di == 0 && dj == 0) return 1'b0;
    if (!c8 && di != 0 && dj != 0) return 1'b0;
    return (i + di >= 0) && (i + di < M) && (j + dj >= 0) && (j + dj < N);
  endfunction

  // Regional maximum: no pixel adjacent to the equal-valued plateau of (si,sj) is higher.
  function automatic bit is_rmax(int si, int sj, bit c8);
    bit seen [M][N];
    int qi[$];
    int qj[$];
    int ci, cj;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        seen[i][j] = 1'b0;
    seen[si][sj] = 1'b1;
    qi.push_back(si);
    qj.push_back(sj);
    while (qi.size() != 0) begin
      ci = qi.pop_front();
      cj = qj.pop_front();
      for (int di = -1; di <= 1; di++)
        for (int dj = -1; dj <= 1; dj++)
          if (nb_ok(di, dj, c8, ci, cj)) begin
            if (img[ci+di][cj+dj] > img[si][sj]) return 1'b0;
            if (img[ci+di][cj+dj] == img[si][sj] && !seen[ci+di][cj+dj]) begin
              seen[ci+di][cj+dj] = 1'b1;
              qi.push_back(ci + di);
              qj.push_back(cj + dj);
            end
          end
    end
    return 1'b1;
  endfunction

  function automatic int model_passes(bit c8);
    bit f [M][N];
    bit chg, hit;
    int p;
    p = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        f[i][j] = 1'b1;
    do begin
      chg = 1'b0;
      p++;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          if (f[i][j]) begin
            hit = 1'b0;
            for (int di = -1; di <= 1; di++)
              for (int dj = -1; dj <= 1; dj++)
                if (nb_ok(di, dj, c8, i, j))
                  if (img[i+di][j+dj] > img[i][j] ||
                      (img[i+di][j+dj] == img[i][j] && !f[i+di][j+dj]))
                    hit = 1'b1;
            if (hit) begin
              f[i][j] = 1'b0;
              chg     = 1'b1;
            end
          end
    end while (chg);
    return p;
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        img[i][j] = v;
  endtask

  task automatic write_px(input logic [2:0] i, input logic [2:0] j, input logic [7:0] v);
    write_en = 1'b1;
    wr_addr  = {i, j};
    pixel_in = v;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic load_img();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        write_px(3'(i), 3'(j), 8'(img[i][j]));
  endtask

  task automatic count_flags(output int ones);
    ones = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        rd_addr = {3'(i), 3'(j)};
        @(negedge clk);
        ones += int'(rd_flag);
      end
  endtask

  task automatic check_flags(input string tag, input bit c8);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        rd_addr = {3'(i), 3'(j)};
        @(negedge clk);
        check($sformatf("%s flag(%0d,%0d)", tag, i, j), rd_flag, is_rmax(i, j, c8));
      end
  endtask

  // Start a run, optionally poke a write and a second start mid-run, then check it all.
  task automatic run_check(input string tag, input bit c8, input bit disturb);
    int n, exp_p;
    bit busy_gap;
    exp_p    = model_passes(c8);
    conn8    = c8;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n        = 1;
    busy_gap = 1'b0;
    while (!done && n < BUDGET) begin
      if (!busy) busy_gap = 1'b1;
      write_en = disturb && (n == 5);
      start    = write_en;
      wr_addr  = 6'd0;
      pixel_in = 8'hff;
      @(negedge clk);
      n++;
    end
    write_en = 1'b0;
    start    = 1'b0;
    check({tag, " done seen"}, done, 1);
    check({tag, " latency"}, n, 2 + exp_p * MN);
    check({tag, " busy held"}, busy_gap, 0);
    check({tag, " busy in FIN"}, busy, 0);
    check({tag, " pass_count"}, pass_count, exp_p);
    @(negedge clk);
    check({tag, " done one cycle"}, done, 0);
    check({tag, " busy after"}, busy, 0);
    check_flags(tag, c8);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ones, ndone;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass_count", pass_count, 0);
    check("rst rd_flag", rd_flag, 0);
    reset_n = 1'b1;
    @(negedge clk);

    fill(5);
    load_img();
    run_check("s1", 1'b1, 1'b0);

    fill(1);
    img[3][2] = 9;
    load_img();
    run_check("s2", 1'b1, 1'b0);
    check("s2 multi-pass", pass_count >= 6'd2, 1);

    fill(0);
    img[1][1] = 7;
    img[2][2] = 8;
    load_img();
    run_check("s3 conn4", 1'b0, 1'b0);
    run_check("s3 conn8", 1'b1, 1'b0);

    fill(5);
    load_img();
    conn8 = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("s4 busy before clear", busy, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("s4 busy after clear", busy, 0);
    ndone = 0;
    repeat (60) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("s4 no done", ndone, 0);
    check("s4 pass_count", pass_count, 0);
    count_flags(ones);
    check("s4 flags cleared", ones, 0);
    run_check("s4 restart", 1'b1, 1'b0);

    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    check("clear beats start", busy, 0);

    write_px(3'd6, 3'd0, 8'd9);
    write_px(3'd7, 3'd7, 8'd9);
    write_px(3'd0, 3'd6, 8'd9);
    write_px(3'd5, 3'd7, 8'd200);
    run_check("s5 busy pokes", 1'b1, 1'b1);
    run_check("s5 rerun", 1'b1, 1'b0);

    fill(1);
    img[3][2] = 9;
    img[5][5] = int'($urandom_range(0, 3));
    load_img();
    conn8 = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    rd_addr = {3'd3, 3'd2};
    repeat (45) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("s6 busy", busy, 0);
    check("s6 done", done, 0);
    check("s6 pass_count", pass_count, 0);
    check("s6 rd_flag", rd_flag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_flags(ones);
    check("s6 flags zero", ones, 0);
    fill(0);
    run_check("s6 zero image", 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          img[i][j] = (r % 3 == 2) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      load_img();
      run_check($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'(r % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
